cpc_ram_bankctl: RTL

CPC_RAM_BANKCTL -- requirements
Module: cpc_ram_bankctl

---
 rtl/cpc_ram_bankctl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cpc_ram_bankctl.sv
// CPC expansion RAM bank controller: captures the bank/mode config from qualified
// I/O writes (data bits 7:6 = 11) and maps Z80 memory blocks onto the external SRAM.
module cpc_ram_bankctl #(
  parameter int BANKBITS    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STROBE_MIN  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adr15,
  input  logic                  adr14,
  input  logic                  adr12,
  input  logic                  adr11,
  input  logic                  iorq_b,
  input  logic                  mreq_b,
  input  logic                  ramrd_b,
  input  logic                  wr_b,
  input  logic [7:0]            datain,
  output logic                  ramdis,
  output logic                  ramcs_b,
  output logic                  ramoe_b,
  output logic                  ramwe_b,
  output logic [BANKBITS+1:0]   ramadrhi,
  output logic [BANKBITS+2:0]   cfg_q,
  output logic                  cfg_wr
);

  typedef enum logic [1:0] {IDLE, QUALIFY, CAPTURE, WAIT_RELEASE} state_e;

  localparam logic [2:0] StrobeMinC = 3'(STROBE_MIN);

  logic [SYNC_STAGES-1:0]      iorqSync_q, wrSync_q, adr15Sync_q;
  logic [SYNC_STAGES-1:0][7:0] dataSync_q;
  logic                        iorqS, wrS, adr15S, strobeS;
  logic [7:0]                  dataS;
  logic [BANKBITS-1:0]         bankD;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d, cntInc;
  logic       loadCfg;

  logic [1:0]          blk, block;
  logic [2:0]          mode;
  logic [BANKBITS-1:0] bank;
  logic                extram, ramrd, ramwr;

  // Bus inputs are asynchronous to clk; reset parks them in the inactive state.
  always_ff @(posedge clk) begin
    if (reset) begin
      iorqSync_q  <= '1;
      wrSync_q    <= '1;
      adr15Sync_q <= '0;
      dataSync_q  <= '0;
    end else begin
      iorqSync_q  <= {iorqSync_q[SYNC_STAGES-2:0], iorq_b};
      wrSync_q    <= {wrSync_q[SYNC_STAGES-2:0], wr_b};
      adr15Sync_q <= {adr15Sync_q[SYNC_STAGES-2:0], adr15};
      dataSync_q  <= {dataSync_q[SYNC_STAGES-2:0], datain};
    end
  end

  assign iorqS   = iorqSync_q[SYNC_STAGES-1];
  assign wrS     = wrSync_q[SYNC_STAGES-1];
  assign adr15S  = adr15Sync_q[SYNC_STAGES-1];
  assign dataS   = dataSync_q[SYNC_STAGES-1];
  assign strobeS = !iorqS && !wrS && !adr15S && dataS[7] && dataS[6];

  // Large configurations take their upper bank bits from the inverted port address.
  if (BANKBITS > 3) begin : gExtBank
    logic [SYNC_STAGES-1:0] adr12Sync_q, adr11Sync_q;
    logic [1:0]             extBank;

    always_ff @(posedge clk) begin
      if (reset) begin
        adr12Sync_q <= '0;
        adr11Sync_q <= '0;
      end else begin
        adr12Sync_q <= {adr12Sync_q[SYNC_STAGES-2:0], adr12};
        adr11Sync_q <= {adr11Sync_q[SYNC_STAGES-2:0], adr11};
      end
    end

    assign extBank = {~adr12Sync_q[SYNC_STAGES-1], ~adr11Sync_q[SYNC_STAGES-1]};
    assign bankD   = {extBank[BANKBITS-4:0], dataS[5:3]};
  end else begin : gNoExtBank
    logic unusedAdr;
    assign unusedAdr = adr12 ^ adr11;
    assign bankD     = dataS[5:3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts low cycles already seen; the current strobe cycle makes it cntInc.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cntInc  = cnt_q + 3'd1;
    case (state_q)
      IDLE: begin
        if (strobeS) begin
          state_d = (STROBE_MIN == 1) ? CAPTURE : QUALIFY;
          cnt_d   = 3'd1;
        end
      end
      QUALIFY: begin
        if (!strobeS) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cntInc == StrobeMinC) begin
          state_d = CAPTURE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cntInc;
        end
      end
      CAPTURE: begin
        state_d = WAIT_RELEASE;
        cnt_d   = 3'd0;
      end
      default: begin
        cnt_d = 3'd0;
        if (!strobeS) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    loadCfg = (state_d == CAPTURE);
    cfg_wr  = (state_q == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
    end else if (loadCfg) begin
      cfg_q <= {bankD, dataS[2:0]};
    end
  end

  assign mode = cfg_q[2:0];
  assign bank = cfg_q[BANKBITS+2:3];
  assign blk  = {adr15, adr14};

  // Modes 1 and 3 behave identically here; 4..7 overlay block 1 only.
  always_comb begin
    extram = 1'b0;
    block  = 2'b00;
    case (mode)
      3'd0: ;
      3'd1, 3'd3: begin
        if (blk == 2'b11) begin
          extram = 1'b1;
          block  = 2'b11;
        end
      end
      3'd2: begin
        extram = 1'b1;
        block  = blk;
      end
      default: begin
        if (blk == 2'b01) begin
          extram = 1'b1;
          block  = mode[1:0];
        end
      end
    endcase
  end

  assign ramadrhi = extram ? {bank, block} : '0;
  assign ramrd    = extram && !ramrd_b;
  assign ramwr    = extram && !wr_b && !mreq_b;
  assign ramcs_b  = !(ramrd || ramwr);
  assign ramoe_b  = !ramrd;
  assign ramwe_b  = !ramwr;
  assign ramdis   = ramrd;

endmodule
